// File: rtl/mul_div_controller.sv
// HI/LO controller for MIPS-style multiply/divide: drives an external multiplier and
// divider, stalls EX while an operation is in flight and owns the HI/LO registers.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | nothing in flight; a valid, unflushed request is accepted
// MUL_WAIT  | counting down the multiplier latency
// DIV_ISSUE | presenting operands to the divider until it takes them
// DIV_WAIT  | divider busy; waiting for its result strobe
// DIV_DRAIN | flushed divide still inside the divider; its result is dropped
module mul_div_controller #(
    parameter int CPU_DATA_WIDTH   = 32,
    parameter int MULTIPLY_LATENCY = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          request_valid,
    input  logic                          request_is_divide,
    input  logic                          request_signed,
    input  logic [CPU_DATA_WIDTH-1:0]     request_source1,
    input  logic [CPU_DATA_WIDTH-1:0]     request_source2,
    input  logic                          flush,
    input  logic                          high_low_write,
    input  logic                          write_high,
    input  logic                          write_low,
    input  logic [CPU_DATA_WIDTH-1:0]     write_value,
    output logic                          stall,
    output logic [CPU_DATA_WIDTH-1:0]     high_value,
    output logic [CPU_DATA_WIDTH-1:0]     low_value,
    output logic [CPU_DATA_WIDTH-1:0]     multiply_source1,
    output logic [CPU_DATA_WIDTH-1:0]     multiply_source2,
    output logic                          multiply_signed,
    input  logic [2*CPU_DATA_WIDTH-1:0]   multiply_product,
    output logic                          divide_request_valid,
    input  logic                          divide_request_ready,
    output logic [CPU_DATA_WIDTH-1:0]     divide_dividend,
    output logic [CPU_DATA_WIDTH-1:0]     divide_divisor,
    output logic                          divide_signed,
    input  logic                          divide_result_valid,
    input  logic [CPU_DATA_WIDTH-1:0]     divide_quotient,
    input  logic [CPU_DATA_WIDTH-1:0]     divide_remainder
);

    localparam int W = CPU_DATA_WIDTH;
    localparam logic [2:0] LAT_LOAD = 3'(MULTIPLY_LATENCY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_WAIT  = 3'd1,
        DIV_ISSUE = 3'd2,
        DIV_WAIT  = 3'd3,
        DIV_DRAIN = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     count_q, count_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   mul_src1_q, mul_src2_q;
    logic           mul_signed_q;
    logic [W-1:0]   div_dividend_q, div_divisor_q;
    logic           div_signed_q;

    logic           accept;
    logic           mul_done;
    logic           div_done;

    assign accept   = (state_q == IDLE) && request_valid && !flush;
    assign mul_done = (state_q == MUL_WAIT) && (count_q == 3'd1);
    assign div_done = (state_q == DIV_WAIT) && divide_result_valid;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = request_is_divide ? DIV_ISSUE : MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (flush || mul_done) begin
                    state_d = IDLE;
                end
            end
            DIV_ISSUE: begin
                // once the divider has the operands a flush must wait for its result
                if (divide_request_ready) begin
                    state_d = flush ? DIV_DRAIN : DIV_WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            DIV_WAIT: begin
                if (divide_result_valid) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DIV_DRAIN;
                end
            end
            DIV_DRAIN: begin
                if (divide_result_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall                = 1'b0;
        divide_request_valid = 1'b0;
        case (state_q)
            IDLE:      stall = request_valid && !flush;
            MUL_WAIT:  stall = !mul_done;
            DIV_ISSUE: begin
                stall                = 1'b1;
                divide_request_valid = 1'b1;
            end
            DIV_WAIT:  stall = !divide_result_valid;
            DIV_DRAIN: stall = request_valid;
            default: begin
                stall                = 1'b0;
                divide_request_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (accept && !request_is_divide) begin
            count_d = LAT_LOAD;
        end else if (state_q == MUL_WAIT) begin
            count_d = flush ? 3'd0 : count_q - 3'd1;
        end
    end

    // completion results override a coincident MTHI/MTLO; a flush suppresses both
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (high_low_write && !flush) begin
            if (write_high) begin
                hi_d = write_value;
            end
            if (write_low) begin
                lo_d = write_value;
            end
        end
        if (mul_done && !flush) begin
            lo_d = multiply_product[W-1:0];
            hi_d = multiply_product[2*W-1:W];
        end else if (div_done && !flush) begin
            lo_d = divide_quotient;
            hi_d = divide_remainder;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q        <= 3'd0;
            hi_q           <= '0;
            lo_q           <= '0;
            mul_src1_q     <= '0;
            mul_src2_q     <= '0;
            mul_signed_q   <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            div_signed_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept && !request_is_divide) begin
                mul_src1_q   <= request_source1;
                mul_src2_q   <= request_source2;
                mul_signed_q <= request_signed;
            end
            if (accept && request_is_divide) begin
                div_dividend_q <= request_source1;
                div_divisor_q  <= request_source2;
                div_signed_q   <= request_signed;
            end
        end
    end

    assign high_value       = hi_q;
    assign low_value        = lo_q;
    assign multiply_source1 = mul_src1_q;
    assign multiply_source2 = mul_src2_q;
    assign multiply_signed  = mul_signed_q;
    assign divide_dividend  = div_dividend_q;
    assign divide_divisor   = div_divisor_q;
    assign divide_signed    = div_signed_q;

endmodule

// File: tb/tb_mul_div_controller.sv
// Self-checking bench for mul_div_controller: random multiply/divide/MTHI/MTLO traffic,
// flush and reset corner cases, checked against arithmetic reference results.
module tb_mul_div_controller;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          request_valid, request_is_divide, request_signed;
    logic [W-1:0]  request_source1, request_source2;
    logic          flush, high_low_write, write_high, write_low;
    logic [W-1:0]  write_value;
    logic          stall;
    logic [W-1:0]  high_value, low_value;
    logic [W-1:0]  multiply_source1, multiply_source2;
    logic          multiply_signed;
    logic [2*W-1:0] multiply_product;
    logic          divide_request_valid, divide_request_ready;
    logic [W-1:0]  divide_dividend, divide_divisor;
    logic          divide_signed, divide_result_valid;
    logic [W-1:0]  divide_quotient, divide_remainder;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  hi_m = '0;
    logic [W-1:0]  lo_m = '0;

    always #5 clock = ~clock;

    mul_div_controller #(.CPU_DATA_WIDTH(W), .MULTIPLY_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .request_valid(request_valid), .request_is_divide(request_is_divide),
        .request_signed(request_signed),
        .request_source1(request_source1), .request_source2(request_source2),
        .flush(flush), .high_low_write(high_low_write),
        .write_high(write_high), .write_low(write_low), .write_value(write_value),
        .stall(stall), .high_value(high_value), .low_value(low_value),
        .multiply_source1(multiply_source1), .multiply_source2(multiply_source2),
        .multiply_signed(multiply_signed), .multiply_product(multiply_product),
        .divide_request_valid(divide_request_valid), .divide_request_ready(divide_request_ready),
        .divide_dividend(divide_dividend), .divide_divisor(divide_divisor),
        .divide_signed(divide_signed), .divide_result_valid(divide_result_valid),
        .divide_quotient(divide_quotient), .divide_remainder(divide_remainder)
    );

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic void div_ref(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // external multiplier with one register stage: product ready LAT cycles after operand load
    always @(posedge clock) multiply_product <= mul_ref(multiply_source1, multiply_source2, multiply_signed);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        request_valid = 0; request_is_divide = 0; request_signed = 0;
        request_source1 = '0; request_source2 = '0; flush = 0;
        high_low_write = 0; write_high = 0; write_low = 0; write_value = '0;
        divide_request_ready = 0; divide_result_valid = 0;
        divide_quotient = '0; divide_remainder = '0;
    endtask

    // presents a multiply until EX advances (or until flush_cycle); returns stalled cycles, -1 on timeout
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int flush_cycle, input logic mt_done, input logic [31:0] mt_val,
                           output int st_cnt);
        bit fin;
        fin = 0;
        request_valid = 1; request_is_divide = 0; request_signed = sgn;
        request_source1 = a; request_source2 = b;
        st_cnt = 0;
        for (int c = 0; c < 32 && !fin; c++) begin
            #1;
            if (stall) st_cnt++;
            else begin
                high_low_write = mt_done; write_high = 1; write_low = 1; write_value = mt_val;
                fin = 1;
            end
            if (c == flush_cycle) begin
                flush = 1;
                fin = 1;
            end
            tick();
        end
        if (!fin) st_cnt = -1;
        idle_inputs();
    endtask

    // presents a divide and acts as the divider: ready after rd valid cycles, result rs cycles later
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int rd, input int rs, output int dv_cnt, output int st_cnt);
        int hs;
        bit fin;
        logic [31:0] env_q, env_r;
        hs = -1; fin = 0; env_q = '0; env_r = '0;
        request_valid = 1; request_is_divide = 1; request_signed = sgn;
        request_source1 = a; request_source2 = b;
        dv_cnt = 0; st_cnt = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            divide_result_valid = (hs >= 0) && (c == hs + rs);
            divide_quotient = env_q; divide_remainder = env_r;
            divide_request_ready = 0;
            #1;
            if (stall) st_cnt++;
            if (divide_request_valid) begin
                if (dv_cnt >= rd && hs < 0) begin
                    divide_request_ready = 1;
                    hs = c;
                    div_ref(divide_dividend, divide_divisor, divide_signed, env_q, env_r);
                end
                dv_cnt++;
            end
            fin = divide_result_valid;
            tick();
        end
        if (!fin) st_cnt = -1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        #1;
        checks++; if (high_value !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", high_value); end
        checks++; if (low_value !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", low_value); end
        checks++; if ({multiply_source1, multiply_source2, multiply_signed} !== '0) begin
            errors++; $display("FAIL reset_mul_ops: got %h %h %b expected 0", multiply_source1, multiply_source2, multiply_signed); end
        checks++; if ({divide_dividend, divide_divisor, divide_signed} !== '0) begin
            errors++; $display("FAIL reset_div_ops: got %h %h %b expected 0", divide_dividend, divide_divisor, divide_signed); end
        checks++; if ({stall, divide_request_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_ctl: got stall=%b dv=%b expected 0 0", stall, divide_request_valid); end
    endtask

    task automatic test_mult_example();
        int st;
        run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, -1, 1'b0, '0, st);
        hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFF1;
        checks++; if (st !== LAT) begin errors++; $display("FAIL mult_stall: got %0d expected %0d", st, LAT); end
        checks++; if (high_value !== hi_m) begin errors++; $display("FAIL mult_hi: got %h expected %h", high_value, hi_m); end
        checks++; if (low_value !== lo_m) begin errors++; $display("FAIL mult_lo: got %h expected %h", low_value, lo_m); end
    endtask

    task automatic test_divu_example();
        int dv, st;
        run_div(32'd100, 32'd7, 1'b0, 1, 17, dv, st);
        hi_m = 32'd2; lo_m = 32'd14;
        checks++; if (dv !== 2) begin errors++; $display("FAIL divu_valid_cycles: got %0d expected 2", dv); end
        checks++; if (st !== 1 + 2 + 16) begin errors++; $display("FAIL divu_stall: got %0d expected 19", st); end
        checks++; if (high_value !== hi_m) begin errors++; $display("FAIL divu_hi: got %h expected %h", high_value, hi_m); end
        checks++; if (low_value !== lo_m) begin errors++; $display("FAIL divu_lo: got %h expected %h", low_value, lo_m); end
    endtask

    task automatic test_hilo_write();
        high_low_write = 1; write_high = 1; write_low = 0; write_value = 32'h1234_5678;
        #1;
        checks++; if (high_value !== hi_m) begin errors++; $display("FAIL mthi_bypass: got %h expected %h", high_value, hi_m); end
        tick();
        idle_inputs();
        hi_m = 32'h1234_5678;
        checks++; if (high_value !== hi_m) begin errors++; $display("FAIL mthi_hi: got %h expected %h", high_value, hi_m); end
        checks++; if (low_value !== lo_m) begin errors++; $display("FAIL mthi_lo: got %h expected %h", low_value, lo_m); end
        for (int i = 0; i < 8; i++) begin
            high_low_write = 1;
            write_high = 1'($urandom_range(0, 1));
            write_low = 1'($urandom_range(0, 1));
            write_value = $urandom();
            flush = ($urandom_range(0, 3) == 0);
            if (!flush && write_high) hi_m = write_value;
            if (!flush && write_low) lo_m = write_value;
            tick();
            idle_inputs();
            checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
                errors++; $display("FAIL mt_rand[%0d]: got %h/%h expected %h/%h", i, high_value, low_value, hi_m, lo_m); end
        end
    endtask

    task automatic test_random_mul();
        int st;
        logic [31:0] a, b;
        logic sgn;
        logic [63:0] p;
        for (int i = 0; i < 8; i++) begin
            a = $urandom(); b = $urandom(); sgn = 1'($urandom_range(0, 1));
            if (i == 0) b = '0;
            p = mul_ref(a, b, sgn);
            run_mul(a, b, sgn, -1, 1'b0, '0, st);
            hi_m = p[63:32]; lo_m = p[31:0];
            checks++; if (st !== LAT) begin errors++; $display("FAIL mul_stall[%0d]: got %0d expected %0d", i, st, LAT); end
            checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
                errors++; $display("FAIL mul_hilo[%0d]: got %h/%h expected %h/%h", i, high_value, low_value, hi_m, lo_m); end
        end
    endtask

    task automatic test_random_div();
        int dv, st, rd, rs;
        logic [31:0] a, b, q, r;
        logic sgn;
        for (int i = 0; i < 8; i++) begin
            a = $urandom(); b = $urandom() >> $urandom_range(0, 28); sgn = 1'($urandom_range(0, 1));
            rd = $urandom_range(0, 3); rs = $urandom_range(1, 12);
            if (i == 0) b = '0;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            div_ref(a, b, sgn, q, r);
            run_div(a, b, sgn, rd, rs, dv, st);
            hi_m = r; lo_m = q;
            checks++; if (dv !== rd + 1) begin errors++; $display("FAIL div_valid_cycles[%0d]: got %0d expected %0d", i, dv, rd + 1); end
            checks++; if (st !== 1 + (rd + 1) + (rs - 1)) begin
                errors++; $display("FAIL div_stall[%0d]: got %0d expected %0d", i, st, 1 + (rd + 1) + (rs - 1)); end
            checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
                errors++; $display("FAIL div_hilo[%0d]: got %h/%h expected %h/%h", i, high_value, low_value, hi_m, lo_m); end
        end
    endtask

    task automatic test_mul_flush_and_override();
        int st;
        logic [31:0] v;
        logic [63:0] p;
        // flush mid-wait, then flush exactly in the completion cycle
        for (int fc = 1; fc <= LAT; fc++) begin
            run_mul($urandom(), $urandom(), 1'b0, fc, 1'b0, '0, st);
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_flush_idle[%0d]: got stall=%b expected 0", fc, stall); end
            tick(); tick();
            checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
                errors++; $display("FAIL mul_flush_hilo[%0d]: got %h/%h expected %h/%h", fc, high_value, low_value, hi_m, lo_m); end
        end
        v = $urandom();
        p = mul_ref(32'd77, 32'd1000, 1'b0);
        run_mul(32'd77, 32'd1000, 1'b0, -1, 1'b1, v, st);
        hi_m = p[63:32]; lo_m = p[31:0];
        checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
            errors++; $display("FAIL mul_beats_mt: got %h/%h expected %h/%h", high_value, low_value, hi_m, lo_m); end
    endtask

    // flush a divide after the divider took it, present MULTU 2x3 while draining, then deliver the stale result
    task automatic test_div_drain(input bit in_issue);
        int st;
        high_low_write = 1; write_high = 1; write_low = 1; write_value = $urandom();
        hi_m = write_value; lo_m = write_value;
        tick();
        idle_inputs();
        request_valid = 1; request_is_divide = 1; request_source1 = 32'd100; request_source2 = 32'd7;
        tick();
        divide_request_ready = 1;
        flush = in_issue;
        tick();
        divide_request_ready = 0;
        if (!in_issue) begin
            tick();
            flush = 1;
            tick();
        end
        flush = 0;
        request_is_divide = 0; request_signed = 0; request_source1 = 32'd2; request_source2 = 32'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({stall, divide_request_valid} !== 2'b10) begin
                errors++; $display("FAIL drain_stall[%0d/%0d]: got stall=%b dv=%b expected 1 0", in_issue, i, stall, divide_request_valid); end
            tick();
        end
        divide_result_valid = 1; divide_quotient = 32'd14; divide_remainder = 32'd2;
        tick();
        divide_result_valid = 0;
        checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
            errors++; $display("FAIL drain_discard[%0d]: got %h/%h expected %h/%h", in_issue, high_value, low_value, hi_m, lo_m); end
        run_mul(32'd2, 32'd3, 1'b0, -1, 1'b0, '0, st);
        hi_m = 32'd0; lo_m = 32'd6;
        checks++; if (st !== LAT) begin errors++; $display("FAIL drain_mul_stall[%0d]: got %0d expected %0d", in_issue, st, LAT); end
        checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
            errors++; $display("FAIL drain_mul_hilo[%0d]: got %h/%h expected %h/%h", in_issue, high_value, low_value, hi_m, lo_m); end
    endtask

    task automatic test_div_flush_to_idle();
        int st;
        logic [63:0] p;
        // flush in DIV_ISSUE before the handshake
        request_valid = 1; request_is_divide = 1; request_source1 = 32'd9; request_source2 = 32'd4;
        tick();
        flush = 1;
        tick();
        idle_inputs();
        #1;
        checks++; if ({stall, divide_request_valid} !== 2'b00) begin
            errors++; $display("FAIL issue_flush_idle: got stall=%b dv=%b expected 0 0", stall, divide_request_valid); end
        // flush in DIV_WAIT coinciding with the result
        request_valid = 1; request_is_divide = 1;
        tick();
        divide_request_ready = 1;
        tick();
        divide_request_ready = 0;
        tick();
        flush = 1; divide_result_valid = 1; divide_quotient = 32'hDEAD; divide_remainder = 32'hBEEF;
        tick();
        idle_inputs();
        checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
            errors++; $display("FAIL wait_flush_result: got %h/%h expected %h/%h", high_value, low_value, hi_m, lo_m); end
        p = mul_ref(32'd11, 32'd13, 1'b1);
        run_mul(32'd11, 32'd13, 1'b1, -1, 1'b0, '0, st);
        hi_m = p[63:32]; lo_m = p[31:0];
        checks++; if (st !== LAT) begin errors++; $display("FAIL wait_flush_next_mul: got %0d expected %0d", st, LAT); end
        checks++; if (low_value !== lo_m) begin errors++; $display("FAIL wait_flush_next_lo: got %h expected %h", low_value, lo_m); end
    endtask

    task automatic test_reset_mid_div();
        int st;
        request_valid = 1; request_is_divide = 1; request_source1 = 32'd50; request_source2 = 32'd3;
        tick();
        divide_request_ready = 1;
        tick();
        divide_request_ready = 0;
        tick();
        request_valid = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
        hi_m = '0; lo_m = '0;
        #1;
        checks++; if ({stall, divide_request_valid} !== 2'b00) begin
            errors++; $display("FAIL rst_div_ctl: got stall=%b dv=%b expected 0 0", stall, divide_request_valid); end
        checks++; if ({high_value, low_value} !== {hi_m, lo_m}) begin
            errors++; $display("FAIL rst_div_hilo: got %h/%h expected 0/0", high_value, low_value); end
        divide_result_valid = 1; divide_quotient = 32'd16; divide_remainder = 32'd2;
        tick();
        idle_inputs();
        #1;
        checks++; if ({high_value, low_value, stall} !== {hi_m, lo_m, 1'b0}) begin
            errors++; $display("FAIL rst_div_strobe: got %h/%h stall=%b expected 0/0 stall=0", high_value, low_value, stall); end
        run_mul(32'd6, 32'd7, 1'b0, -1, 1'b0, '0, st);
        lo_m = 32'd42;
        checks++; if ({st, low_value} !== {LAT, lo_m}) begin
            errors++; $display("FAIL rst_div_recover: got st=%0d lo=%h expected st=%0d lo=%h", st, low_value, LAT, lo_m); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult_example();
        test_divu_example();
        test_hilo_write();
        test_random_mul();
        test_random_div();
        test_mul_flush_and_override();
        test_div_drain(1'b0);
        test_div_drain(1'b1);
        test_div_flush_to_idle();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
